// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port between
// NumReq producers. A grant is held for a burst that ends on an EOP word or
// after MaxBurst accepted words.
// Optional build macro FIFO_WR_ARB_PKT_LOCK_EN: grants last for a whole
// packet (EOP only), and a sticky burst_over output flags packets longer
// than MaxBurst words.
module fifo_wr_arbiter #(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned Width    = 9,
  parameter int unsigned MaxBurst = 8,
  localparam int unsigned GW      = $clog2(NumReq)
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic [NumReq-1:0]       req_valid,
  input  logic [NumReq*Width-1:0] req_data,
  output logic [NumReq-1:0]       req_ready,
  output logic [Width-1:0]        fifo_din,
  output logic                    fifo_wr_en,
  input  logic                    fifo_full,
  input  logic                    fifo_prog_full,
  output logic [GW-1:0]           grant_id,
  output logic                    busy
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
  ,
  output logic                    burst_over
`endif
);

  localparam int unsigned CW = $clog2(MaxBurst + 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     burst_cnt;
  logic [Width-1:0]  words [NumReq];
  logic [Width-1:0]  sel_word;
  logic              pick_found;
  logic [GW-1:0]     pick_idx;
  logic [GW-1:0]     cand_idx;
  int unsigned       cand;
  logic              start;
  logic              accept;
  logic              eop;
  logic              rel;

  // Split the flat producer bus into one word per producer.
  always_comb begin
    for (int unsigned i = 0; i < NumReq; i++) begin
      words[i] = req_data[i*Width +: Width];
    end
  end

  // Round-robin pick: scan from the producer after the last grant.
  // grant_id only changes when a new grant starts, so it already holds the
  // last granted index and doubles as the round-robin pointer.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int unsigned k = 1; k <= NumReq; k++) begin
      cand     = (int'(grant_id) + k) % NumReq;
      cand_idx = GW'(cand);
      if (!pick_found && req_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign sel_word = words[grant_id];
  assign accept   = (state == GRANT) && req_valid[grant_id] && !fifo_full;
  assign eop      = sel_word[Width-1];

`ifdef FIFO_WR_ARB_PKT_LOCK_EN
  assign rel = accept && eop;
`else
  assign rel = accept && (eop || (burst_cnt == CW'(MaxBurst - 1)));
`endif

  assign busy = (state == GRANT);

  // Next-state and FIFO/producer handshake outputs.
  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    case (state)
      IDLE: begin
        if (pick_found && !fifo_prog_full) begin
          start     = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        req_ready[grant_id] = !fifo_full;
        fifo_wr_en          = accept;
        if (accept) begin
          fifo_din = sel_word;
        end
        if (rel) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant pointer and burst counter registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      state     <= IDLE;
      grant_id  <= GW'(NumReq - 1);
      burst_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        grant_id  <= pick_idx;
        burst_cnt <= '0;
      end else if (accept) begin
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
        if (burst_cnt != CW'(MaxBurst)) begin
          burst_cnt <= burst_cnt + 1'b1;
        end
`else
        burst_cnt <= burst_cnt + 1'b1;
`endif
      end
    end
  end

`ifdef FIFO_WR_ARB_PKT_LOCK_EN
  // Sticky flag: a word accepted after MaxBurst words of the same packet.
  always_ff @(posedge clk) begin
    if (srst) begin
      burst_over <= 1'b0;
    end else if (accept && (burst_cnt == CW'(MaxBurst))) begin
      burst_over <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed-vector bench for fifo_wr_arbiter (default
// build, NumReq=4, Width=9, MaxBurst=8). Inputs change 1 ns after the
// rising edge, outputs are sampled 2 ns after it.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int W  = 9;

  logic            clk;
  logic            srst;
  logic [NR-1:0]   req_valid;
  logic [NR*W-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic [W-1:0]    fifo_din;
  logic            fifo_wr_en;
  logic            fifo_full;
  logic            fifo_prog_full;
  logic [1:0]      grant_id;
  logic            busy;

  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter #(
    .NumReq  (NR),
    .Width   (W),
    .MaxBurst(8)
  ) dut (
    .clk           (clk),
    .srst          (srst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .fifo_din      (fifo_din),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_full     (fifo_full),
    .fifo_prog_full(fifo_prog_full),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic b, input int gid,
                            input int rdy, input logic wr, input int din);
    chk({tag, "_busy"},  32'(busy),       32'(b));
    chk({tag, "_gid"},   32'(grant_id),   32'(gid));
    chk({tag, "_ready"}, 32'(req_ready),  32'(rdy));
    chk({tag, "_wren"},  32'(fifo_wr_en), 32'(wr));
    chk({tag, "_din"},   32'(fifo_din),   32'(din));
    chk({tag, "_oh"},    32'($onehot0(req_ready)), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [W-1:0] w);
    req_data[i*W +: W] = w;
  endtask

  task automatic do_reset();
    srst = 1'b1;
    step();
    srst = 1'b0;
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    srst           = 1'b1;
    req_valid      = '0;
    req_data       = '0;
    fifo_full      = 1'b0;
    fifo_prog_full = 1'b0;

    // Reset state
    do_reset();
    #1 expect_out("rst", 1'b0, 3, 0, 1'b0, 0);

    // Single producer, three-word packet
    req_valid = 4'b0001;
    set_word(0, 9'h011);
    #1 expect_out("t1idle", 1'b0, 3, 0, 1'b0, 0);
    step(); #1 expect_out("t1w0", 1'b1, 0, 1, 1'b1, 'h011);
    step(); set_word(0, 9'h022); #1 expect_out("t1w1", 1'b1, 0, 1, 1'b1, 'h022);
    step(); set_word(0, 9'h133); #1 expect_out("t1w2", 1'b1, 0, 1, 1'b1, 'h133);
    step(); req_valid = '0; #1 expect_out("t1done", 1'b0, 0, 0, 1'b0, 0);

    // Round-robin, one-word EOP packets from all producers
    do_reset();
    #1 expect_out("rst2", 1'b0, 3, 0, 1'b0, 0);
    req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) set_word(i, 9'(9'h1A0 + i));
    #1 expect_out("t2idle", 1'b0, 3, 0, 1'b0, 0);
    for (int n = 0; n < 5; n++) begin
      step(); #1 expect_out("t2g", 1'b1, order[n], 1 << order[n], 1'b1, 'h1A0 + order[n]);
      step(); #1 expect_out("t2gap", 1'b0, order[n], 0, 1'b0, 0);
    end
    req_valid = '0;

    // Burst limit: ten words without EOP from producer 2
    do_reset();
    req_valid = 4'b0100;
    set_word(2, 9'h040);
    #1 expect_out("t3idle", 1'b0, 3, 0, 1'b0, 0);
    for (int w = 0; w < 8; w++) begin
      step(); set_word(2, 9'(9'h040 + w)); #1 expect_out("t3a", 1'b1, 2, 4, 1'b1, 'h040 + w);
    end
    step(); set_word(2, 9'h048); #1 expect_out("t3gap", 1'b0, 2, 0, 1'b0, 0);
    for (int w = 8; w < 10; w++) begin
      step(); set_word(2, 9'(9'h040 + w)); #1 expect_out("t3b", 1'b1, 2, 4, 1'b1, 'h040 + w);
    end
    step(); req_valid = '0; #1 expect_out("t3stall", 1'b1, 2, 4, 1'b0, 0);

    // Backpressure: FIFO starts at 13 entries, fills to 16, reader pops 2
    do_reset();
    req_valid = 4'b0010;
    set_word(1, 9'h060);
    #1 expect_out("t4idle", 1'b0, 3, 0, 1'b0, 0);
    step(); #1 expect_out("t4w0", 1'b1, 1, 2, 1'b1, 'h060);
    step(); set_word(1, 9'h061); fifo_prog_full = 1'b1;
    #1 expect_out("t4w1", 1'b1, 1, 2, 1'b1, 'h061);
    step(); set_word(1, 9'h062); #1 expect_out("t4d15", 1'b1, 1, 2, 1'b1, 'h062);
    step(); set_word(1, 9'h063); fifo_full = 1'b1;
    #1 expect_out("t4full0", 1'b1, 1, 0, 1'b0, 0);
    step(); #1 expect_out("t4full1", 1'b1, 1, 0, 1'b0, 0);
    step(); fifo_full = 1'b0; #1 expect_out("t4w3", 1'b1, 1, 2, 1'b1, 'h063);
    step(); set_word(1, 9'h164); #1 expect_out("t4w4", 1'b1, 1, 2, 1'b1, 'h164);
    step(); req_valid = '0; fifo_full = 1'b1; #1 expect_out("t4done", 1'b0, 1, 0, 1'b0, 0);

    // prog_full gating in IDLE
    do_reset();
    fifo_full      = 1'b0;
    fifo_prog_full = 1'b1;
    req_valid      = 4'b0001;
    set_word(0, 9'h1AA);
    #1 expect_out("t5hold0", 1'b0, 3, 0, 1'b0, 0);
    for (int c = 0; c < 3; c++) begin
      step(); #1 expect_out("t5hold", 1'b0, 3, 0, 1'b0, 0);
    end
    step(); fifo_prog_full = 1'b0; #1 expect_out("t5drop", 1'b0, 3, 0, 1'b0, 0);
    step(); #1 expect_out("t5grant", 1'b1, 0, 1, 1'b1, 'h1AA);
    step(); req_valid = '0; #1 expect_out("t5done", 1'b0, 0, 0, 1'b0, 0);

    // Reset mid-burst from producer 3
    req_valid = 4'b1000;
    set_word(3, 9'h070);
    #1 expect_out("t6idle", 1'b0, 0, 0, 1'b0, 0);
    step(); #1 expect_out("t6w0", 1'b1, 3, 8, 1'b1, 'h070);
    step(); set_word(3, 9'h071); #1 expect_out("t6w1", 1'b1, 3, 8, 1'b1, 'h071);
    step(); set_word(3, 9'h072); srst = 1'b1;
    step(); srst = 1'b0; req_valid = 4'b1001; set_word(0, 9'h1BB);
    #1 expect_out("t6rst", 1'b0, 3, 0, 1'b0, 0);
    step(); #1 expect_out("t6regrant", 1'b1, 0, 1, 1'b1, 'h1BB);
    step(); req_valid = '0; #1 expect_out("t6done", 1'b0, 0, 0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
